// File: rtl/onehot_encoder_pipe_pkg.sv
// Shared widths, buffer state encoding and result record for the one-hot encoder pipe.
// Also provides the constant bit masks used by the index OR-tree.
package onehot_encoder_pipe_pkg;

    localparam int DIN_W    = 32;
    localparam int DOUT_W   = 5;
    localparam int ERRCNT_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    typedef struct packed {
        logic              err;
        logic [DOUT_W-1:0] idx;
    } result_t;

    // Mask of every input position whose index has bit b set.
    function automatic logic [DIN_W-1:0] idx_mask(input int b);
        logic [DIN_W-1:0] m;
        m = '0;
        for (int i = 0; i < DIN_W; i++) begin
            m[i] = ((i >> b) & 1) != 0;
        end
        return m;
    endfunction

endpackage

// File: rtl/onehot_encoder_pipe_check_enc.sv
// Combinational lowest-set-bit encoder with a legality check (exactly one bit set).
// The lowest bit is isolated first so each index bit becomes a plain OR over a fixed mask.
module onehot_check_enc
    import onehot_encoder_pipe_pkg::*;
(
    input  logic [DIN_W-1:0]  din,
    output logic [DOUT_W-1:0] idx,
    output logic              err
);

    logic [DIN_W-1:0] low_bit;

    // Two's-complement trick: keeps only the least significant set bit.
    assign low_bit = din & (~din + 1'b1);

    genvar gi;
    generate
        for (gi = 0; gi < DOUT_W; gi++) begin : g_idx
            localparam logic [DIN_W-1:0] MASK = idx_mask(gi);
            assign idx[gi] = |(low_bit & MASK);
        end
    endgenerate

    // Illegal when empty or when clearing the lowest bit still leaves something set.
    assign err = (din == '0) || ((din & (din - 1'b1)) != '0);

endmodule

// File: rtl/onehot_encoder_pipe.sv
// Registered 32-to-5 one-hot encoder with valid/ready on both sides, a 2-entry
// output buffer (head drives dout) and a saturating illegal-vector counter.
module onehot_encoder_pipe
    import onehot_encoder_pipe_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic [DIN_W-1:0]    din,
    output logic                dout_valid,
    input  logic                dout_ready,
    output logic [DOUT_W-1:0]   dout,
    output logic                dout_err,
    output logic [ERRCNT_W-1:0] err_cnt,
    input  logic                err_clr
);

    buf_state_t          state_reg, state_next;
    result_t             head_reg, tail_reg;
    logic                din_ready_reg;
    logic                dout_valid_reg;
    logic [ERRCNT_W-1:0] err_cnt_reg;

    logic                push, pop;
    logic [DOUT_W-1:0]   enc_idx;
    logic                enc_err;
    result_t             enc_res;

    onehot_check_enc u_check_enc (
        .din (din),
        .idx (enc_idx),
        .err (enc_err)
    );

    assign enc_res = '{err: enc_err, idx: enc_idx};

    assign push = din_valid & din_ready_reg;
    assign pop  = dout_valid_reg & dout_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)      state_next = FULL;
                else if (!push && pop) state_next = EMPTY;
            end
            FULL:    if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // Handshake flags are registered from the next state, so din_ready never
    // depends combinationally on dout_ready and stays low throughout reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= EMPTY;
            din_ready_reg  <= 1'b0;
            dout_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            din_ready_reg  <= (state_next != FULL);
            dout_valid_reg <= (state_next != EMPTY);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            case (state_reg)
                EMPTY: if (push) head_reg <= enc_res;
                ONE: begin
                    if (push && pop) head_reg <= enc_res;
                    else if (push)   tail_reg <= enc_res;
                end
                FULL:    if (pop) head_reg <= tail_reg;
                default: ;
            endcase
        end
    end

    // Counted at acceptance; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else if (err_clr) begin
            err_cnt_reg <= '0;
        end else if (push && enc_err && (err_cnt_reg != '1)) begin
            err_cnt_reg <= err_cnt_reg + 1'b1;
        end
    end

    assign din_ready  = din_ready_reg;
    assign dout_valid = dout_valid_reg;
    assign dout       = head_reg.idx;
    assign dout_err   = head_reg.err;
    assign err_cnt    = err_cnt_reg;

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Self-checking bench: directed table and sequences plus randomized traffic
// checked by a queue-based reference model sampled on the falling edge.
module tb_onehot_encoder_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [31:0] din = '0;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [4:0]  dout;
    logic        dout_err;
    logic [7:0]  err_cnt;
    logic        err_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0] idx;
        logic       err;
    } exp_t;

    typedef struct {
        logic [31:0] din;
        logic [4:0]  idx;
        logic        err;
    } vec_t;

    exp_t model_q[$];
    int   exp_cnt = 0;
    logic rdy_exp = 1'b0;

    onehot_encoder_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din        (din),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_err   (dout_err),
        .err_cnt    (err_cnt),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: index of the lowest set bit; legal only with exactly one bit set.
    function automatic exp_t ref_enc(input logic [31:0] v);
        exp_t r;
        r.idx = '0;
        for (int k = 31; k >= 0; k--) begin
            if (v[k]) r.idx = 5'(k);
        end
        r.err = ($countones(v) != 1);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Falling-edge monitor: compare against the model, then apply the transfers
    // that the coming rising edge will perform.
    always @(negedge clk) begin
        if (rst) begin
            model_q.delete();
            exp_cnt = 0;
            rdy_exp = 1'b0;
            check("rst_dout_valid", 32'(dout_valid), 32'd0);
            check("rst_din_ready", 32'(din_ready), 32'd0);
            check("rst_err_cnt", 32'(err_cnt), 32'd0);
            check("rst_dout", 32'(dout), 32'd0);
            check("rst_dout_err", 32'(dout_err), 32'd0);
        end else begin
            check("mon_din_ready", 32'(din_ready), 32'(rdy_exp));
            check("mon_dout_valid", 32'(dout_valid), 32'(model_q.size() != 0));
            check("mon_err_cnt", 32'(err_cnt), 32'(exp_cnt));
            if (dout_valid && model_q.size() != 0) begin
                check("mon_dout", 32'(dout), 32'(model_q[0].idx));
                check("mon_dout_err", 32'(dout_err), 32'(model_q[0].err));
            end
            if (dout_valid && dout_ready && model_q.size() != 0) void'(model_q.pop_front());
            if (din_valid && din_ready) begin
                exp_t e;
                e = ref_enc(din);
                model_q.push_back(e);
                if (e.err && exp_cnt < 255) exp_cnt++;
            end
            if (err_clr) exp_cnt = 0;
            rdy_exp = (model_q.size() < 2);
        end
    end

    vec_t tbl [0:5];

    initial begin
        tbl[0] = '{din: 32'h0000_0001, idx: 5'd0,  err: 1'b0};
        tbl[1] = '{din: 32'h8000_0000, idx: 5'd31, err: 1'b0};
        tbl[2] = '{din: 32'h0000_0000, idx: 5'd0,  err: 1'b1};
        tbl[3] = '{din: 32'h0000_0014, idx: 5'd2,  err: 1'b1};
        tbl[4] = '{din: 32'hFFFF_FFFF, idx: 5'd0,  err: 1'b1};
        tbl[5] = '{din: 32'h0001_0000, idx: 5'd16, err: 1'b0};

        // Reset and first ready
        repeat (3) @(posedge clk);
        #1;
        check("reset_dout_valid", 32'(dout_valid), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
        check("reset_din_ready", 32'(din_ready), 32'd0);
        rst = 1'b0;
        check("ready_held_low", 32'(din_ready), 32'd0);
        step();
        check("ready_after_reset", 32'(din_ready), 32'd1);

        // Sweep of legal one-hot vectors at full throughput
        dout_ready = 1'b1;
        for (int k = 0; k < 32; k++) begin
            din = 32'd1 << k;
            din_valid = 1'b1;
            step();
            check("sweep_valid", 32'(dout_valid), 32'd1);
            check("sweep_dout", 32'(dout), 32'(k));
            check("sweep_err", 32'(dout_err), 32'd0);
            check("sweep_ready", 32'(din_ready), 32'd1);
        end
        din_valid = 1'b0;
        step();
        check("sweep_err_cnt", 32'(err_cnt), 32'd0);

        // Illegal vectors
        din = 32'h0; din_valid = 1'b1;
        step();
        check("zero_dout", 32'(dout), 32'd0);
        check("zero_err", 32'(dout_err), 32'd1);
        din = 32'h0000_0014;
        step();
        check("multi_dout", 32'(dout), 32'd2);
        check("multi_err", 32'(dout_err), 32'd1);
        din_valid = 1'b0;
        step();
        check("illegal_err_cnt", 32'(err_cnt), 32'd2);

        // Table-driven vectors
        for (int i = 0; i < 6; i++) begin
            din = tbl[i].din;
            din_valid = 1'b1;
            step();
            check("tbl_valid", 32'(dout_valid), 32'd1);
            check("tbl_dout", 32'(dout), 32'(tbl[i].idx));
            check("tbl_err", 32'(dout_err), 32'(tbl[i].err));
        end
        din_valid = 1'b0;
        step();
        check("tbl_err_cnt", 32'(err_cnt), 32'd5);

        // Backpressure into FULL, then drain in order
        dout_ready = 1'b0;
        din = 32'h8; din_valid = 1'b1;
        step();
        din = 32'h100;
        step();
        din_valid = 1'b0;
        check("bp_ready_low", 32'(din_ready), 32'd0);
        check("bp_dout_first", 32'(dout), 32'd3);
        for (int i = 0; i < 2; i++) begin
            step();
            check("bp_dout_stable", 32'(dout), 32'd3);
            check("bp_valid_held", 32'(dout_valid), 32'd1);
        end
        dout_ready = 1'b1;
        step();
        check("bp_dout_second", 32'(dout), 32'd8);
        check("bp_ready_back", 32'(din_ready), 32'd1);
        step();
        check("bp_drained", 32'(dout_valid), 32'd0);

        // Simultaneous push and pop in ONE
        dout_ready = 1'b0;
        din = 32'h2; din_valid = 1'b1;
        step();
        din = 32'h4000_0000; dout_ready = 1'b1;
        step();
        din_valid = 1'b0;
        check("simul_valid", 32'(dout_valid), 32'd1);
        check("simul_dout", 32'(dout), 32'd30);
        check("simul_ready", 32'(din_ready), 32'd1);
        step();
        check("simul_drained", 32'(dout_valid), 32'd0);

        // Counter saturation, then clear beating a same-cycle increment
        din = 32'h3; din_valid = 1'b1;
        for (int i = 0; i < 300; i++) step();
        check("sat_err_cnt", 32'(err_cnt), 32'd255);
        err_clr = 1'b1; din = 32'h0;
        step();
        err_clr = 1'b0; din_valid = 1'b0;
        check("clr_err_cnt", 32'(err_cnt), 32'd0);
        step();

        // Async reset while FULL, asserted between edges
        dout_ready = 1'b0;
        din = 32'h0; din_valid = 1'b1;
        step();
        din = 32'h6;
        step();
        din_valid = 1'b0;
        check("pre_rst_full", 32'(din_ready), 32'd0);
        check("pre_rst_cnt", 32'(err_cnt), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(dout_valid), 32'd0);
        check("arst_err_cnt", 32'(err_cnt), 32'd0);
        check("arst_ready", 32'(din_ready), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("arst_ready_back", 32'(din_ready), 32'd1);
        din = 32'h1; din_valid = 1'b1; dout_ready = 1'b1;
        step();
        din_valid = 1'b0;
        check("arst_new_valid", 32'(dout_valid), 32'd1);
        check("arst_new_dout", 32'(dout), 32'd0);
        check("arst_new_err", 32'(dout_err), 32'd0);
        step();
        check("arst_no_stale", 32'(dout_valid), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0:       din = 32'd1 << $urandom_range(0, 31);
                1:       din = 32'h0;
                2:       din = $urandom;
                default: din = (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31));
            endcase
            din_valid  = ($urandom_range(0, 3) != 0);
            dout_ready = ($urandom_range(0, 2) != 0);
            err_clr    = ($urandom_range(0, 40) == 0);
            step();
        end
        din_valid = 1'b0;
        err_clr   = 1'b0;
        dout_ready = 1'b1;

        // Bounded drain
        for (int i = 0; i < 10 && dout_valid; i++) step();
        check("drain_done", 32'(dout_valid), 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
